out_gain: RTL and testbench
===========================

OUT_GAIN -- requirements
Module: out_gain

Interface
REQ-001 Parameter SIG_BITS, default 16, sample width of the in and out ports.
REQ-002 Parameter GAIN_BITS, default 8, width of the gain control.
REQ-003 Parameter UNITY_SHIFT, default 7: gain code 2^UNITY_SHIFT (128) is 1.0x.
REQ-004 Parameter CLIP_HOLD, default 4800: number of output samples clip_led stays lit after a clip.
REQ-005 Port clk, input, 1 bit: single clock for the block (clk_50 domain).
REQ-006 Port reset_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-007 Port in, input, SIG_BITS: offset-binary sample from the delay stage; 0x8000 is midscale.
REQ-008 Port in_valid, input, 1 bit: one-cycle strobe marking a new sample on in.
REQ-009 Port gain, input, GAIN_BITS: target gain code from the analog controls (unsigned).
REQ-010 Port out, output, SIG_BITS: offset-binary sample to the DAC SPI stage.
REQ-011 Port out_valid, output, 1 bit: one-cycle strobe that qualifies out; it drives the DAC go input.
REQ-012 Port clip, output, 1 bit: pulse coincident with out_valid when that sample saturated.
REQ-013 Port clip_led, output, 1 bit: stretched clip indicator.

Function
REQ-014 Sample decode: on acceptance, the block SHALL convert in to signed s by inverting its MSB.
REQ-015 Effective gain: the block SHALL hold register g_eff (GAIN_BITS, unsigned) and multiply each accepted sample by the g_eff value present in the acceptance cycle.
REQ-016 Ramp: on the same edge as each accepted sample, g_eff SHALL step toward gain.
 - +1 if g_eff < gain.
 - -1 if g_eff > gain.
 - Unchanged if g_eff == gain.
 - g_eff SHALL NOT change in cycles where in_valid=0.
REQ-017 Multiply: stage 1 SHALL register p = s * g_eff as a signed product of at least SIG_BITS+GAIN_BITS+1 bits.
REQ-018 Scale: stage 2 SHALL form q = p arithmetically shifted right by UNITY_SHIFT (floor rounding, toward minus infinity).
REQ-019 Saturate: q SHALL be clamped to [-32768, 32767] (generally the SIG_BITS signed range).
 - The clamped value is registered to out with its MSB inverted (offset binary).
REQ-020 Latency: in_valid high in cycle N SHALL produce out_valid high for exactly one cycle in cycle N+2.
REQ-021 Throughput: the pipeline SHALL accept in_valid in every cycle with no stall or backpressure; back-to-back inputs give back-to-back outputs in order.
REQ-022 Hold: out SHALL keep its last value between out_valid strobes.
REQ-023 Clip pulse: clip SHALL be 1 only in a cycle where out_valid=1 and REQ-019 clamped that sample; otherwise 0.
REQ-024 Clip hold counter: the block SHALL keep a counter c.
 - c loads CLIP_HOLD on each clipped output.
 - c decrements by 1 on each non-clipped out_valid while c>0.
 - clip_led SHALL equal (c != 0).
 - A clip on the same output that would decrement c SHALL win (reload).
REQ-025 Zero gain: with g_eff=0, out SHALL be 0x8000 (midscale) for every sample.
REQ-026 Gain changes: a change on gain mid-stream SHALL affect output only through the ramp of REQ-016, never as a step.

Reset
REQ-027 While reset_n=0, the block SHALL hold:
 - out = 0x8000, out_valid = 0
 - clip = 0, clip_led = 0, c = 0
 - g_eff = 0, all pipeline valid flags = 0.
REQ-028 Reset mid-operation SHALL discard in-flight samples; no out_valid SHALL be produced for samples accepted before the reset.
REQ-029 After reset release, the first in_valid SHALL be accepted normally; output fades in from mute via the ramp.

Verification
REQ-030 Fade-in: reset, gain=128, in=0xC000 on every 4th cycle -> first out=0x8000; out rises monotonically; the 129th and later outputs = 0xC000 (g_eff=128).
REQ-031 Latency/throughput: in_valid on cycles 10,11,12 -> out_valid on cycles 12,13,14 only, in order; no out_valid elsewhere.
REQ-032 Saturation: g_eff=255, in=0xFFFF -> out=0xFFFF, clip=1, clip_led=1; then in=0x0000 -> out=0x0000, clip=1; then in=0x8000 -> out=0x8000, clip=0.
REQ-033 Floor rounding: g_eff=64, in=0x7FFF (s=-1) -> out=0x7FFF; in=0x8001 (s=+1) -> out=0x8000.
REQ-034 Ramp down / idle: g_eff=128, gain set to 0 -> g_eff unchanged over 1000 cycles without in_valid; reaches 0 after exactly 128 accepted samples.
REQ-035 Reset mid-stream: assert reset_n=0 with both pipeline stages valid -> out_valid=0 and out=0x8000 immediately; after release, no stale out_valid; clip_led=0 after a prior clip.

Source files
------------

// File: rtl/out_gain.sv
// Output gain stage: offset-binary sample times a slowly ramped gain code.
// Two-stage pipeline (multiply, then scale/saturate) with a stretched clip indicator.
module out_gain #(
    parameter int SIG_BITS    = 16,
    parameter int GAIN_BITS   = 8,
    parameter int UNITY_SHIFT = 7,
    parameter int CLIP_HOLD   = 4800
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [SIG_BITS-1:0]  in,
    input  logic                 in_valid,
    input  logic [GAIN_BITS-1:0] gain,
    output logic [SIG_BITS-1:0]  out,
    output logic                 out_valid,
    output logic                 clip,
    output logic                 clip_led
);

    localparam int PW = SIG_BITS + GAIN_BITS + 1;
    localparam int CW = (CLIP_HOLD < 1) ? 1 : $clog2(CLIP_HOLD + 1);

    localparam logic signed [PW-1:0] SAT_MAX = {{(PW-SIG_BITS+1){1'b0}}, {(SIG_BITS-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(PW-SIG_BITS+1){1'b1}}, {(SIG_BITS-1){1'b0}}};

    logic [GAIN_BITS-1:0]       g_eff_q, g_eff_d;
    logic signed [PW-1:0]       s_ext, g_ext;
    logic signed [PW-1:0]       p_q, p_d;
    logic                       v1_q;
    logic signed [PW-1:0]       q;
    logic signed [SIG_BITS-1:0] qc;
    logic                       sat;
    logic [SIG_BITS-1:0]        out_q, out_d;
    logic                       out_valid_q;
    logic                       clip_q, clip_d;
    logic [CW-1:0]              cnt_q, cnt_d;

    // Stage 1: decode offset binary, multiply by the gain in effect this cycle, ramp gain.
    always_comb begin
        s_ext = PW'($signed({~in[SIG_BITS-1], in[SIG_BITS-2:0]}));
        g_ext = $signed(PW'({1'b0, g_eff_q}));
        p_d   = s_ext * g_ext;

        g_eff_d = g_eff_q;
        if (in_valid) begin
            if (g_eff_q < gain)
                g_eff_d = g_eff_q + GAIN_BITS'(1);
            else if (g_eff_q > gain)
                g_eff_d = g_eff_q - GAIN_BITS'(1);
        end
    end

    // Stage 2: floor-scale, clamp to the signed sample range, re-encode offset binary.
    always_comb begin
        q   = p_q >>> UNITY_SHIFT;
        sat = 1'b0;
        qc  = q[SIG_BITS-1:0];
        if (q > SAT_MAX) begin
            sat = 1'b1;
            qc  = {1'b0, {(SIG_BITS-1){1'b1}}};
        end else if (q < SAT_MIN) begin
            sat = 1'b1;
            qc  = {1'b1, {(SIG_BITS-1){1'b0}}};
        end

        out_d  = out_q;
        clip_d = 1'b0;
        cnt_d  = cnt_q;
        if (v1_q) begin
            out_d  = {~qc[SIG_BITS-1], qc[SIG_BITS-2:0]};
            clip_d = sat;
            // A clip reloads the hold even when this output would otherwise count down.
            if (sat)
                cnt_d = CW'(CLIP_HOLD);
            else if (cnt_q != '0)
                cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            g_eff_q     <= '0;
            p_q         <= '0;
            v1_q        <= 1'b0;
            out_q       <= {1'b1, {(SIG_BITS-1){1'b0}}};
            out_valid_q <= 1'b0;
            clip_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            g_eff_q     <= g_eff_d;
            if (in_valid)
                p_q     <= p_d;
            v1_q        <= in_valid;
            out_q       <= out_d;
            out_valid_q <= v1_q;
            clip_q      <= clip_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign clip      = clip_q;
    assign clip_led  = (cnt_q != '0);

endmodule

// File: tb/tb_out_gain.sv
// Directed bench for out_gain: steady-gain vector table plus fade, latency,
// ramp, clip-hold and mid-stream reset sequences.
module tb_out_gain;

    logic        clk;
    logic        reset_n;
    logic [15:0] in;
    logic        in_valid;
    logic [7:0]  gain;
    logic [15:0] out;
    logic        out_valid;
    logic        clip;
    logic        clip_led;

    int ncmp = 0;
    int nerr = 0;
    int cyc  = 0;

    typedef struct {
        logic [15:0] o;
        logic        c;
        logic        l;
        int          cyc;
    } obs_t;
    obs_t mq[$];

    typedef struct {
        logic [7:0]  g;
        logic [15:0] din;
        logic [15:0] exp_out;
        logic        exp_clip;
    } vec_t;
    vec_t vt[11];

    out_gain #(
        .SIG_BITS(16),
        .GAIN_BITS(8),
        .UNITY_SHIFT(7),
        .CLIP_HOLD(5)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .in(in),
        .in_valid(in_valid),
        .gain(gain),
        .out(out),
        .out_valid(out_valid),
        .clip(clip),
        .clip_led(clip_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (out_valid) mq.push_back('{out, clip, clip_led, cyc});

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [15:0] v);
        in       = v;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_q(input int n);
        for (int t = 0; t < 200 && mq.size() < n; t++) @(posedge clk);
        #1;
        if (mq.size() < n) begin
            ncmp++;
            nerr++;
            $display("FAIL wait_q: got %0d outputs expected %0d", mq.size(), n);
        end
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in       = 16'h8000;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        mq.delete();
    endtask

    initial begin
        int base;
        logic        is_clip[16];
        logic        exp_led[16];

        vt[0]  = '{8'd255, 16'hFFFF, 16'hFFFF, 1'b1};
        vt[1]  = '{8'd255, 16'h0000, 16'h0000, 1'b1};
        vt[2]  = '{8'd255, 16'h8000, 16'h8000, 1'b0};
        vt[3]  = '{8'd64,  16'h7FFF, 16'h7FFF, 1'b0};
        vt[4]  = '{8'd64,  16'h8001, 16'h8000, 1'b0};
        vt[5]  = '{8'd128, 16'h1234, 16'h1234, 1'b0};
        vt[6]  = '{8'd0,   16'hFFFF, 16'h8000, 1'b0};
        vt[7]  = '{8'd200, 16'hA000, 16'hB200, 1'b0};
        vt[8]  = '{8'd192, 16'h2000, 16'h0000, 1'b1};
        vt[9]  = '{8'd3,   16'h8055, 16'h8001, 1'b0};
        vt[10] = '{8'd3,   16'h7FAB, 16'h7FFE, 1'b0};

        gain     = 8'd0;
        in       = 16'h8000;
        in_valid = 1'b0;
        reset_n  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", 32'(out), 32'h8000);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_clip", 32'(clip), 32'd0);
        check("rst_clip_led", 32'(clip_led), 32'd0);

        // Steady-gain table: ramp g_eff to the target with midscale, then apply the vector.
        for (int i = 0; i < 11; i++) begin
            do_reset();
            gain = vt[i].g;
            for (int k = 0; k < int'(vt[i].g); k++) send(16'h8000);
            send(vt[i].din);
            wait_q(int'(vt[i].g) + 1);
            if (mq.size() > int'(vt[i].g)) begin
                check($sformatf("vec%0d_out", i), 32'(mq[vt[i].g].o), 32'(vt[i].exp_out));
                check($sformatf("vec%0d_clip", i), 32'(mq[vt[i].g].c), 32'(vt[i].exp_clip));
            end
        end

        // Fade-in from mute.
        do_reset();
        gain = 8'd128;
        for (int k = 0; k < 140; k++) begin
            send(16'hC000);
            repeat (3) @(posedge clk);
            #1;
        end
        wait_q(140);
        for (int k = 0; k < 140 && k < mq.size(); k++)
            check($sformatf("fade%0d", k), 32'(mq[k].o), 32'(32768 + 128 * ((k > 128) ? 128 : k)));

        // Latency / throughput.
        do_reset();
        gain = 8'd128;
        base = cyc;
        while (cyc - base < 10) begin
            @(posedge clk);
            #1;
        end
        send(16'hC000);
        send(16'hC000);
        send(16'hC000);
        repeat (10) @(posedge clk);
        #1;
        check("lat_count", 32'(mq.size()), 32'd3);
        for (int k = 0; k < 3 && k < mq.size(); k++) begin
            check($sformatf("lat_cyc%0d", k), 32'(mq[k].cyc - base), 32'(12 + k));
            check($sformatf("lat_out%0d", k), 32'(mq[k].o), 32'(32768 + 128 * k));
        end

        // Ramp down, idle hold.
        do_reset();
        gain = 8'd128;
        repeat (128) send(16'h8000);
        gain = 8'd0;
        repeat (1000) @(posedge clk);
        #1;
        mq.delete();
        repeat (130) send(16'hC000);
        wait_q(130);
        if (mq.size() >= 130) begin
            check("down_first", 32'(mq[0].o), 32'hC000);
            check("down_127", 32'(mq[127].o), 32'h8080);
            check("down_128", 32'(mq[128].o), 32'h8000);
            check("down_129", 32'(mq[129].o), 32'h8000);
        end

        // Clip hold counter with reload (hold = 5 outputs).
        do_reset();
        gain = 8'd255;
        repeat (255) send(16'h8000);
        repeat (3) @(posedge clk);
        #1;
        mq.delete();
        for (int k = 0; k < 16; k++) begin
            is_clip[k] = (k == 0 || k == 6 || k == 10);
            exp_led[k] = !(k == 5 || k == 15);
        end
        for (int k = 0; k < 16; k++) send(is_clip[k] ? 16'hFFFF : 16'h8000);
        wait_q(16);
        for (int k = 0; k < 16 && k < mq.size(); k++) begin
            check($sformatf("hold_out%0d", k), 32'(mq[k].o), is_clip[k] ? 32'hFFFF : 32'h8000);
            check($sformatf("hold_clip%0d", k), 32'(mq[k].c), 32'(is_clip[k]));
            check($sformatf("hold_led%0d", k), 32'(mq[k].l), 32'(exp_led[k]));
        end

        // Reset with both stages full.
        repeat (3) @(posedge clk);
        #1;
        send(16'hFFFF);
        send(16'h8000);
        check("mid_pre_valid", 32'(out_valid), 32'd1);
        check("mid_pre_led", 32'(clip_led), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_out_valid", 32'(out_valid), 32'd0);
        check("mid_out", 32'(out), 32'h8000);
        check("mid_clip", 32'(clip), 32'd0);
        check("mid_clip_led", 32'(clip_led), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        mq.delete();
        repeat (10) @(posedge clk);
        #1;
        check("mid_no_stale", 32'(mq.size()), 32'd0);
        send(16'hFFFF);
        wait_q(1);
        if (mq.size() >= 1) begin
            check("mid_mute_out", 32'(mq[0].o), 32'h8000);
            check("mid_mute_clip", 32'(mq[0].c), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
